// File: rtl/digital_lock_pkg.sv
// Shared types and defaults for the digital lock datapath.
// Holds the lockout FSM state type, the 2-bit fail-count type that the
// wrong-attempt counter also produces, and the default timing constants
// used by lockout_controller.
package digital_lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKED  = 2'd1,
    RELEASE = 2'd2
  } lock_state_t;

  typedef logic [1:0] fail_count_t;

  localparam int DEF_LOCK_SECS  = 30;
  localparam int DEF_ALARM_SECS = 5;
  localparam int DEF_MAX_FAILS  = 3;
  localparam int DEF_REM_W      = 8;

endpackage

// File: rtl/sec_down_counter.sv
// Tick-enabled, loadable seconds down counter.
// Ports:
//   clk        - system clock
//   rst_n      - synchronous active-low reset, clears the count
//   i_load     - load i_loadVal this edge (wins over a coincident tick)
//   i_loadVal  - value to load
//   i_tick     - decrement enable, one-clk strobe
//   o_count    - current count
//   o_zero     - count is zero
//   o_hitOne   - a tick is about to take the count from 1 to 0
module sec_down_counter
  import digital_lock_pkg::*;
#(
  parameter int W = DEF_REM_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic         i_tick,
  output logic [W-1:0] o_count,
  output logic         o_zero,
  output logic         o_hitOne
);

  logic [W-1:0] r_count;

  // Load has priority so a tick landing on the load edge is dropped.
  // The count holds at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_zero   = (r_count == '0);
  assign o_hitOne = i_tick && !i_load && (r_count == W'(1));

endmodule

// File: rtl/lockout_controller.sv
// Keypad lockout controller, downstream of the wrong-attempt counter.
// When the synchronised fail count reaches MAX_FAILS the keypad is locked
// for a timed period with an alarm for the first ALARM_SECS seconds; on
// expiry the attempt counter is held in reset until it reads zero.
// A correct password while unlocked pulses clr_fail for one clock.
// Optional build macro: LOCKOUT_ESCALATE_EN doubles the lockout duration
// for each consecutive lockout (up to 8x), cleared by an accepted pass_ok.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   tick_1hz     - one-clk strobe per second
//   fail_count   - wrong-attempt count, asynchronous to clk
//   pass_ok      - one-clk strobe, correct password entered
//   locked       - keypad must ignore input
//   alarm        - buzzer/LED drive
//   clr_fail     - level reset for the attempt counter
//   remaining    - seconds left in the current lockout
module lockout_controller
  import digital_lock_pkg::*;
#(
  parameter int LOCK_SECS  = DEF_LOCK_SECS,
  parameter int MAX_FAILS  = DEF_MAX_FAILS,
  parameter int ALARM_SECS = DEF_ALARM_SECS,
  parameter int REM_W      = DEF_REM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  fail_count_t      fail_count,
  input  logic             pass_ok,
  output logic             locked,
  output logic             alarm,
  output logic             clr_fail,
  output logic [REM_W-1:0] remaining
);

  fail_count_t      r_fcMeta;
  fail_count_t      r_fcSync;
  lock_state_t      r_state;
  lock_state_t      w_nextState;
  logic             r_clrPulse;
  logic             w_load;
  logic             w_passAccept;
  logic             w_cntTick;
  logic             w_fcAtMax;
  logic [REM_W-1:0] w_duration;
  logic [REM_W-1:0] w_elapsed;
  logic [REM_W-1:0] w_count;
  logic             w_zero;
  logic             w_hitOne;

  // fail_count comes from the button domain; every decision uses r_fcSync.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fcMeta <= '0;
      r_fcSync <= '0;
    end else begin
      r_fcMeta <= fail_count;
      r_fcSync <= r_fcMeta;
    end
  end

  assign w_fcAtMax = (r_fcSync >= fail_count_t'(MAX_FAILS));

`ifdef LOCKOUT_ESCALATE_EN
  logic [1:0] r_lockLevel;

  // Escalation level rises on each expiry and is forgiven by a good entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lockLevel <= 2'd0;
    end else if (w_passAccept) begin
      r_lockLevel <= 2'd0;
    end else if ((r_state == LOCKED) && (w_nextState == RELEASE) &&
                 (r_lockLevel != 2'd3)) begin
      r_lockLevel <= r_lockLevel + 2'd1;
    end
  end

  assign w_duration = REM_W'(LOCK_SECS) << r_lockLevel;
`else
  assign w_duration = REM_W'(LOCK_SECS);
`endif

  // Ticks only count down while LOCKED; the entry edge is in IDLE, so a
  // coincident tick is ignored.
  assign w_cntTick = tick_1hz && (r_state == LOCKED);

  sec_down_counter #(
    .W(REM_W)
  ) u_secCounter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_loadVal(w_duration),
    .i_tick   (w_cntTick),
    .o_count  (w_count),
    .o_zero   (w_zero),
    .o_hitOne (w_hitOne)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_clrPulse <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_clrPulse <= w_passAccept;
    end
  end

  // Lock entry outranks pass_ok. w_zero in LOCKED cannot normally occur
  // (duration >= 1) but guarantees the FSM never sits locked at zero.
  always_comb begin
    w_nextState  = r_state;
    w_load       = 1'b0;
    w_passAccept = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fcAtMax) begin
          w_nextState = LOCKED;
          w_load      = 1'b1;
        end else if (pass_ok) begin
          w_passAccept = 1'b1;
        end
      end
      LOCKED: begin
        if (w_hitOne || w_zero) begin
          w_nextState = RELEASE;
        end
      end
      RELEASE: begin
        if (r_fcSync == '0) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Alarm covers the first ALARM_SECS elapsed seconds of the lockout.
  assign w_elapsed = w_duration - w_count;

  always_comb begin
    locked    = 1'b0;
    alarm     = 1'b0;
    clr_fail  = r_clrPulse;
    remaining = w_count;
    case (r_state)
      LOCKED: begin
        locked = 1'b1;
        alarm  = (w_elapsed < REM_W'(ALARM_SECS));
      end
      RELEASE: begin
        locked   = 1'b1;
        clr_fail = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/lockout_controller.md
Name: lockout_controller

Overview:
- Sits directly downstream of the saturating 2-bit wrong-attempt counter.
- Watches the counter's value. When it reaches MAX_FAILS, freezes the keypad for a timed lockout and raises an alarm.
- At lockout expiry, clears the attempt counter through its reset input.
- Also clears the counter when the comparator reports a correct password while unlocked.

Parameters:
- LOCK_SECS, 30: base lockout duration in seconds. Legal range 1..(2^REM_W-1)>>3.
- MAX_FAILS, 3: fail_count value that triggers lockout. Legal range 1..3.
- ALARM_SECS, 5: number of leading seconds of a lockout during which alarm is high. Must be <= LOCK_SECS.
- REM_W, 8: width of the remaining-seconds counter.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: synchronous active-low reset.
- tick_1hz, in, 1: one-clk strobe, once per second, synchronous to clk.
- fail_count, in, 2: value from the wrong-attempt counter. Asynchronous to clk (button domain).
- pass_ok, in, 1: one-clk strobe from the password comparator, meaning correct entry.
- locked, out, 1: high while the keypad must ignore input.
- alarm, out, 1: buzzer/LED drive.
- clr_fail, out, 1: drives the attempt counter's reset. Active-high, level.
- remaining, out, REM_W: seconds left in the current lockout. 0 when not locked.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; locked=0, alarm=0, clr_fail=0, remaining=0.
  - Synchroniser flops and lock level are cleared.
- Input synchronisation: fail_count passes through a 2-flop synchroniser into fc_s, giving 2 clk of latency. Every decision uses fc_s only.
- States are IDLE, LOCKED, RELEASE.
- IDLE:
  - If fc_s >= MAX_FAILS: next state LOCKED. At the same edge, load remaining=duration and set locked=1, alarm=1.
  - Else if pass_ok: clr_fail=1 for exactly 1 clk and stay in IDLE.
  - The fc_s >= MAX_FAILS check has priority over pass_ok when both occur in the same cycle.
- LOCKED:
  - On tick_1hz, remaining decrements by 1.
  - alarm drops on the tick that makes (duration - remaining) reach ALARM_SECS.
  - On the tick that takes remaining from 1 to 0: next state RELEASE, alarm=0.
  - A tick coincident with the IDLE->LOCKED entry edge is ignored, so the first decrement happens on the next tick.
  - pass_ok is ignored.
- RELEASE:
  - clr_fail=1 and locked=1 are held until fc_s==0.
  - On the edge after fc_s==0 is seen: clr_fail=0, locked=0, state IDLE.
  - No timeout.
- Sync reset mid-lockout returns to IDLE. If fail_count is still >= MAX_FAILS, the block re-enters LOCKED 1 clk after fc_s is valid (≤3 clk). Reset must not bypass the lockout.
- remaining never underflows. Ticks arriving in IDLE or RELEASE are ignored.

Optional Feature:
- Macro: LOCKOUT_ESCALATE_EN.
- With the macro defined:
  - A 2-bit lock_level (0..3) is kept.
  - duration = LOCK_SECS << lock_level.
  - lock_level increments (saturating at 3) at each LOCKED->RELEASE transition.
  - lock_level clears to 0 on pass_ok accepted in IDLE, and on reset.
- Without the macro: duration = LOCK_SECS for every lockout, and no lock_level register exists.

Decomposition:
- Package digital_lock_pkg holds:
  - state typedef lock_state_t {IDLE, LOCKED, RELEASE};
  - localparams DEF_LOCK_SECS and DEF_ALARM_SECS;
  - the 2-bit fail-count type shared with the attempt counter.
- Sub-module sec_down_counter: a tick-enabled loadable REM_W down counter with a zero flag and a "hit 1 on tick" flag. It is instantiated once here.

Test Plan:
1. Three wrong attempts: drive fail_count 0->3.
   - Required: locked=1 and remaining=30 within 3 clk; alarm=1.
   - After 5 ticks: alarm=0, remaining=25.
   - After 30 ticks: clr_fail=1.
   - Model fail_count->0; locked=0 within 3 clk of that.
2. pass_ok with fail_count=2: clr_fail high exactly 1 clk; locked stays 0.
3. pass_ok during LOCKED at remaining=12: no clr_fail, and countdown continues 12->11 on the next tick.
4. rst_n low for 1 clk at remaining=17 with fail_count held at 3:
   - Outputs zero the cycle after reset.
   - Relock with remaining=30 within 3 clk after rst_n high.
5. Tick on the same clk as lock entry: remaining still 30 after that edge; 29 after the next tick.
6. LOCKOUT_ESCALATE_EN defined, three consecutive lockouts: remaining loads 30, then 60, then 120. pass_ok in IDLE, then a new lockout: loads 30.
